pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on posedge CLK.
REQ-002 SHALL have port RESET, input, 1, synchronous active-high reset, sampled on posedge CLK only.
REQ-003 SHALL have input MEM_BUSYWAIT, 1: data memory busy; MEM-stage access is incomplete.
REQ-004 SHALL have input IMEM_BUSYWAIT, 1: instruction memory busy; fetch is incomplete.
REQ-005 SHALL have inputs MEM_READ_EN_IDEX, 1, and REG_WRITE_ADDR_IDEX, 5: load flag and destination register of the instruction in EX.
REQ-006 SHALL have inputs ADDR_1_ID, ADDR_2_ID, 5 each, plus RS1_USED_ID, RS2_USED_ID, 1 each: source registers of the ID instruction and their use flags.
REQ-007 SHALL have input BRANCH_TAKEN_EX, 1: a branch or jump in EX resolved taken, so the PC is redirected.
REQ-008 SHALL have inputs MULDIV_REQ_EX, 1 (mul/div instruction in EX) and MULDIV_DONE, 1 (level; held high until acknowledged).
REQ-009 SHALL have outputs PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, MEMWB_STALL, 1 each: hold the register.
REQ-010 SHALL have outputs IFID_RESET, IDEX_RESET, EXMEM_RESET, 1 each: load a bubble (all-zero) into the register.
REQ-011 SHALL have outputs MULDIV_START, 1 (single-cycle pulse) and MULDIV_ACK, 1 (single-cycle pulse).
REQ-012 SHALL have outputs STALL_CNT, 16, and FLUSH_CNT, 16 (saturating performance counters), plus STATE, 2 (debug).

Function
REQ-013 SHALL implement FSM states RUN=2'b00 and MD_WAIT=2'b01; encodings 2'b10 and 2'b11 SHALL return to RUN on the next edge.
REQ-014 SHALL drive all stall, reset, START and ACK outputs combinationally from the current state and inputs, so they act in the same cycle.
REQ-015 SHALL apply priority 1, highest: MEM_BUSYWAIT=1 asserts all five stalls and deasserts all resets, START and ACK; state and counters hold, except STALL_CNT.
REQ-016 SHALL apply priority 2, in RUN: BRANCH_TAKEN_EX=1 asserts IFID_RESET and IDEX_RESET with PC_STALL=0, so the redirect wins even if IMEM_BUSYWAIT=1; FLUSH_CNT increments.
REQ-017 SHALL apply priority 3, in RUN: MULDIV_REQ_EX=1 asserts MULDIV_START, PC_STALL, IFID_STALL, IDEX_STALL and EXMEM_RESET; next state is MD_WAIT.
REQ-018 SHALL handle MD_WAIT as follows: hold PC_STALL, IFID_STALL, IDEX_STALL and EXMEM_RESET while MULDIV_DONE=0; BRANCH_TAKEN_EX and MULDIV_REQ_EX are ignored.
REQ-019 SHALL, in MD_WAIT with MULDIV_DONE=1 and MEM_BUSYWAIT=0, assert MULDIV_ACK, deassert all stalls and resets (so EX/MEM captures the result) and go to RUN.
REQ-020 SHALL apply priority 4, in RUN: a load-use hazard asserts PC_STALL, IFID_STALL and IDEX_RESET for that cycle only.
REQ-021 SHALL define a load-use hazard as MEM_READ_EN_IDEX=1, REG_WRITE_ADDR_IDEX!=0, and a match with (ADDR_1_ID with RS1_USED_ID=1) or (ADDR_2_ID with RS2_USED_ID=1).
REQ-022 SHALL apply priority 5, in RUN: IMEM_BUSYWAIT=1 asserts PC_STALL and IFID_RESET (bubble into ID) with the downstream stages advancing.
REQ-023 SHALL, with no condition active, deassert all stall/reset/START/ACK outputs.
REQ-024 SHALL increment STALL_CNT in every cycle with PC_STALL=1, saturating at 16'hFFFF.
REQ-025 SHALL increment FLUSH_CNT per REQ-016 event, saturating at 16'hFFFF.
REQ-026 SHALL issue MULDIV_START at most once per mul/div instruction: START is never asserted in MD_WAIT, nor in the ACK cycle.

Reset
REQ-027 SHALL, when RESET=1 at a posedge, set STATE=RUN, STALL_CNT=0, FLUSH_CNT=0, overriding all other inputs, including mid-MD_WAIT.
REQ-028 SHALL, during any cycle with RESET=1, drive all stall outputs 0, START/ACK 0, and IFID_RESET, IDEX_RESET, EXMEM_RESET 1.

Verification
REQ-029 SHALL cover load-use: EX holds a load to x5 and ID reads rs2=x5 -> exactly 1 cycle of PC_STALL=IFID_STALL=IDEX_RESET=1, STALL_CNT=1; with rd=x0 -> no stall.
REQ-030 SHALL cover mul/div: MULDIV_REQ_EX=1, DONE after 4 cycles -> START pulse in cycle 0, STATE=MD_WAIT for cycles 1-4, ACK in cycle 4, STALL_CNT=4, then STATE=RUN.
REQ-031 SHALL cover branch with hazard: BRANCH_TAKEN_EX=1 with a simultaneous load-use match and IMEM_BUSYWAIT=1 -> IFID_RESET=IDEX_RESET=1, PC_STALL=0, FLUSH_CNT=1.
REQ-032 SHALL cover memory busy: MEM_BUSYWAIT=1 for 3 cycles while in MD_WAIT with DONE=1 -> all stalls 1 and no ACK for 3 cycles, ACK in the first cycle after busy drops.
REQ-033 SHALL cover saturation and reset: preload via 65540 stall cycles -> STALL_CNT=16'hFFFF holds; RESET asserted in MD_WAIT -> next cycle STATE=RUN and counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard status inputs and stall/flush controls of the pipeline hazard controller
interface pipeline_hazard_ctrl_if;
  logic        MEM_BUSYWAIT;
  logic        IMEM_BUSYWAIT;
  logic        MEM_READ_EN_IDEX;
  logic [4:0]  REG_WRITE_ADDR_IDEX;
  logic [4:0]  ADDR_1_ID;
  logic [4:0]  ADDR_2_ID;
  logic        RS1_USED_ID;
  logic        RS2_USED_ID;
  logic        BRANCH_TAKEN_EX;
  logic        MULDIV_REQ_EX;
  logic        MULDIV_DONE;

  logic        PC_STALL;
  logic        IFID_STALL;
  logic        IDEX_STALL;
  logic        EXMEM_STALL;
  logic        MEMWB_STALL;
  logic        IFID_RESET;
  logic        IDEX_RESET;
  logic        EXMEM_RESET;
  logic        MULDIV_START;
  logic        MULDIV_ACK;
  logic [15:0] STALL_CNT;
  logic [15:0] FLUSH_CNT;
  logic [1:0]  STATE;

  // Pipeline side: reports stage status, obeys the controls.
  modport master (
    output MEM_BUSYWAIT, IMEM_BUSYWAIT, MEM_READ_EN_IDEX, REG_WRITE_ADDR_IDEX,
           ADDR_1_ID, ADDR_2_ID, RS1_USED_ID, RS2_USED_ID, BRANCH_TAKEN_EX,
           MULDIV_REQ_EX, MULDIV_DONE,
    input  PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, MEMWB_STALL,
           IFID_RESET, IDEX_RESET, EXMEM_RESET, MULDIV_START, MULDIV_ACK,
           STALL_CNT, FLUSH_CNT, STATE
  );

  modport slave (
    input  MEM_BUSYWAIT, IMEM_BUSYWAIT, MEM_READ_EN_IDEX, REG_WRITE_ADDR_IDEX,
           ADDR_1_ID, ADDR_2_ID, RS1_USED_ID, RS2_USED_ID, BRANCH_TAKEN_EX,
           MULDIV_REQ_EX, MULDIV_DONE,
    output PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL, MEMWB_STALL,
           IFID_RESET, IDEX_RESET, EXMEM_RESET, MULDIV_START, MULDIV_ACK,
           STALL_CNT, FLUSH_CNT, STATE
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - five-stage pipeline stall/flush controller with mul/div wait FSM and perf counters
module pipeline_hazard_ctrl (
  input  logic                         CLK,
  input  logic                         RESET,
  pipeline_hazard_ctrl_if.slave        hz
);
  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] MD_WAIT = 2'b01;

  logic [1:0]  state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
  logic ifid_reset, idex_reset, exmem_reset, md_start, md_ack, flush_evt;
  logic load_use;

  assign load_use = hz.MEM_READ_EN_IDEX && (hz.REG_WRITE_ADDR_IDEX != 5'd0) &&
                    ((hz.RS1_USED_ID && (hz.ADDR_1_ID == hz.REG_WRITE_ADDR_IDEX)) ||
                     (hz.RS2_USED_ID && (hz.ADDR_2_ID == hz.REG_WRITE_ADDR_IDEX)));

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    memwb_stall = 1'b0;
    ifid_reset  = 1'b0;
    idex_reset  = 1'b0;
    exmem_reset = 1'b0;
    md_start    = 1'b0;
    md_ack      = 1'b0;
    flush_evt   = 1'b0;
    state_d     = state_q;

    if (RESET) begin
      ifid_reset  = 1'b1;
      idex_reset  = 1'b1;
      exmem_reset = 1'b1;
      state_d     = RUN;
    end else if (hz.MEM_BUSYWAIT) begin
      // Data memory stall freezes the whole pipe; unused encodings still recover.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_stall = 1'b1;
      if (state_q != MD_WAIT) state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.BRANCH_TAKEN_EX) begin
            ifid_reset = 1'b1;
            idex_reset = 1'b1;
            flush_evt  = 1'b1;
          end else if (hz.MULDIV_REQ_EX) begin
            md_start    = 1'b1;
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_reset = 1'b1;
            state_d     = MD_WAIT;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_reset = 1'b1;
          end else if (hz.IMEM_BUSYWAIT) begin
            pc_stall   = 1'b1;
            ifid_reset = 1'b1;
          end
        end
        MD_WAIT: begin
          if (hz.MULDIV_DONE) begin
            // All controls released so EX/MEM captures the unit's result.
            md_ack  = 1'b1;
            state_d = RUN;
          end else begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_reset = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    flush_cnt_d = flush_cnt_q;
    if (flush_evt && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= RUN;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.PC_STALL     = pc_stall;
  assign hz.IFID_STALL   = ifid_stall;
  assign hz.IDEX_STALL   = idex_stall;
  assign hz.EXMEM_STALL  = exmem_stall;
  assign hz.MEMWB_STALL  = memwb_stall;
  assign hz.IFID_RESET   = ifid_reset;
  assign hz.IDEX_RESET   = idex_reset;
  assign hz.EXMEM_RESET  = exmem_reset;
  assign hz.MULDIV_START = md_start;
  assign hz.MULDIV_ACK   = md_ack;
  assign hz.STALL_CNT    = stall_cnt_q;
  assign hz.FLUSH_CNT    = flush_cnt_q;
  assign hz.STATE        = state_q;
endmodule
